// File: rtl/envelope_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : envelope_frame_reader
//  Purpose  : Captures envelogram samples into a ping-pong pair of frame
//             banks, tracks the per-frame peak and hands completed frames to
//             a software reader through a ready/ack handshake and a
//             registered random-access read port.
//  Revision : 1.0 - initial release
// ============================================================================
module envelope_frame_reader #(
    parameter int FRAME_LEN = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              frame_ready,
    input  logic              frame_ack,
    output logic [31:0]       frame_max,
    output logic [15:0]       frame_cnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              overflow
);

    // Write FSM encoding
    localparam logic [0:0] c_FILL      = 1'b0;
    localparam logic [0:0] c_FULL_WAIT = 1'b1;
    // Reader FSM encoding
    localparam logic [0:0] c_IDLE      = 1'b0;
    localparam logic [0:0] c_HOLD      = 1'b1;

    localparam logic [ADDR_W-1:0] c_IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Bank storage; contents are intentionally not reset
    logic [31:0] bank0_q [FRAME_LEN];
    logic [31:0] bank1_q [FRAME_LEN];

    logic [0:0]        wstate_q, wstate_d;
    logic [0:0]        rstate_q, rstate_d;
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
    logic [31:0]       run_max_q, run_max_d;
    logic [31:0]       frame_max_q, frame_max_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              overflow_q, overflow_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic              w_wr_en;
    logic              w_drop;
    logic              w_last_wr;
    logic              w_swap;
    logic              w_reader_free;
    logic [31:0]       w_max_new;

    // Running peak including the sample being written this cycle
    assign w_max_new     = (in_data > run_max_q) ? in_data : run_max_q;
    assign w_reader_free = (rstate_q == c_IDLE) || frame_ack;

    // Write FSM state register
    always_ff @(posedge CLK) begin
        if (RST) wstate_q <= c_FILL;
        else     wstate_q <= wstate_d;
    end

    // Write FSM next state: park in FULL_WAIT when a frame completes while
    // the reader still owns the other bank
    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            c_FILL:      if (w_last_wr && !w_reader_free) wstate_d = c_FULL_WAIT;
            c_FULL_WAIT: if (frame_ack)                   wstate_d = c_FILL;
            default:                                      wstate_d = c_FILL;
        endcase
    end

    // Write FSM outputs: bank write, sample drop and swap strobes
    always_comb begin
        w_wr_en   = 1'b0;
        w_drop    = 1'b0;
        w_last_wr = 1'b0;
        w_swap    = 1'b0;
        case (wstate_q)
            c_FILL: begin
                w_wr_en   = in_valid;
                w_last_wr = in_valid && (&wr_idx_q);
                w_swap    = w_last_wr && w_reader_free;
            end
            c_FULL_WAIT: begin
                w_drop = in_valid;
                w_swap = frame_ack;
            end
            default: ;
        endcase
    end

    // Reader FSM state register
    always_ff @(posedge CLK) begin
        if (RST) rstate_q <= c_IDLE;
        else     rstate_q <= rstate_d;
    end

    // Reader FSM next state: a swap always lands in HOLD, even on an ack edge
    always_comb begin
        rstate_d = rstate_q;
        if (w_swap)
            rstate_d = c_HOLD;
        else if ((rstate_q == c_HOLD) && frame_ack)
            rstate_d = c_IDLE;
    end

    // Reader FSM output
    always_comb begin
        frame_ready = (rstate_q == c_HOLD);
    end

    // Stream-side datapath next state: index, peak, handoff and overflow
    always_comb begin
        wr_idx_d    = wr_idx_q;
        run_max_d   = run_max_q;
        wr_bank_d   = wr_bank_q;
        frame_max_d = frame_max_q;
        frame_cnt_d = frame_cnt_q;
        overflow_d  = overflow_q | w_drop;
        if (w_wr_en) begin
            wr_idx_d  = wr_idx_q + c_IDX_ONE;
            run_max_d = w_max_new;
        end
        if (w_swap) begin
            wr_bank_d   = ~wr_bank_q;
            wr_idx_d    = '0;
            // In FULL_WAIT the peak already includes the final sample
            frame_max_d = (wstate_q == c_FILL) ? w_max_new : run_max_q;
            run_max_d   = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Stream-side datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_idx_q    <= '0;
            run_max_q   <= '0;
            wr_bank_q   <= 1'b0;
            frame_max_q <= '0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_idx_q    <= wr_idx_d;
            run_max_q   <= run_max_d;
            wr_bank_q   <= wr_bank_d;
            frame_max_q <= frame_max_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    // Bank write: only ever the stream-owned bank
    always_ff @(posedge CLK) begin
        if (w_wr_en && !RST) begin
            if (wr_bank_q) bank1_q[wr_idx_q] <= in_data;
            else           bank0_q[wr_idx_q] <= in_data;
        end
    end

    // Read result: the reader-owned bank is the one not being written
    always_comb begin
        rd_valid_d = rd_req;
        rd_data_d  = '0;
        if (rd_req && (rstate_q == c_HOLD))
            rd_data_d = wr_bank_q ? bank0_q[rd_addr] : bank1_q[rd_addr];
    end

    // Read port registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign frame_max = frame_max_q;
    assign frame_cnt = frame_cnt_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_envelope_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_envelope_frame_reader
//  Purpose  : Directed self-checking bench for envelope_frame_reader.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_envelope_frame_reader;

    localparam int FRAME_LEN = 256;
    localparam int ADDR_W    = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic [31:0]       in_data;
    logic              in_valid;
    logic              frame_ready;
    logic              frame_ack;
    logic [31:0]       frame_max;
    logic [15:0]       frame_cnt;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic              overflow;

    int n_checks = 0;
    int n_pass   = 0;

    envelope_frame_reader #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .frame_ready(frame_ready),
        .frame_ack  (frame_ack),
        .frame_max  (frame_max),
        .frame_cnt  (frame_cnt),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .overflow   (overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Continuous stream of n samples: base + i*mul, one per cycle
    task automatic stream(input logic [31:0] base, input logic [31:0] mul, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(i) * mul;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        rd_req  = 1'b0;
        check_eq({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check_eq({tag, "_data"}, rd_data, exp);
    endtask

    task automatic pulse_ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        RST = 1'b1;
        repeat (cycles) tick();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b0; in_data = '0; in_valid = 1'b0; frame_ack = 1'b0;
        rd_req = 1'b0; rd_addr = '0;
        #2;

        // ---- Reset state ----
        do_reset(2);
        check_eq("rst_ready", {31'd0, frame_ready}, 32'd0);
        check_eq("rst_max",   frame_max, 32'd0);
        check_eq("rst_cnt",   {16'd0, frame_cnt}, 32'd0);
        check_eq("rst_rdata", rd_data, 32'd0);
        check_eq("rst_rvalid",{31'd0, rd_valid}, 32'd0);
        check_eq("rst_ovf",   {31'd0, overflow}, 32'd0);
        do_read("idle_rd5", 8'd5, 32'd0);
        tick();
        check_eq("rvalid_pulse", {31'd0, rd_valid}, 32'd0);

        // ack in IDLE is ignored
        pulse_ack();
        check_eq("idle_ack_ready", {31'd0, frame_ready}, 32'd0);
        check_eq("idle_ack_cnt",   {16'd0, frame_cnt}, 32'd0);

        // ---- Single frame: i*3 ----
        stream(32'd0, 32'd3, 255);
        check_eq("f1_ready_early", {31'd0, frame_ready}, 32'd0);
        stream(32'd765, 32'd0, 1);
        check_eq("f1_ready", {31'd0, frame_ready}, 32'd1);
        check_eq("f1_max",   frame_max, 32'd765);
        check_eq("f1_cnt",   {16'd0, frame_cnt}, 32'd1);
        do_read("f1_rd0",   8'd0,   32'd0);
        do_read("f1_rd100", 8'd100, 32'd300);
        do_read("f1_rd255", 8'd255, 32'd765);
        // back-to-back reads
        rd_req = 1'b1; rd_addr = 8'd1; tick();
        check_eq("b2b_a_data", rd_data, 32'd3);
        rd_addr = 8'd2; tick();
        rd_req = 1'b0;
        check_eq("b2b_b_data", rd_data, 32'd6);
        check_eq("b2b_b_valid", {31'd0, rd_valid}, 32'd1);

        // ---- Gapped input with peak ----
        pulse_ack();
        check_eq("ack_release", {31'd0, frame_ready}, 32'd0);
        do_read("rel_rd", 8'd1, 32'd0);
        for (int i = 0; i < FRAME_LEN; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 37) ? 32'h8000_0000 : 32'd10;
            tick();
            in_valid = 1'b0;
            repeat (3) tick();
        end
        check_eq("gap_max",  frame_max, 32'h8000_0000);
        check_eq("gap_cnt",  {16'd0, frame_cnt}, 32'd2);
        do_read("gap_rd37", 8'd37, 32'h8000_0000);
        do_read("gap_rd36", 8'd36, 32'd10);

        // ---- Ping-pong without ack ----
        do_reset(1);
        stream(32'd0, 32'd1, 256);
        check_eq("pp_a_cnt", {16'd0, frame_cnt}, 32'd1);
        check_eq("pp_a_max", frame_max, 32'd255);
        stream(32'd1000, 32'd1, 256);
        check_eq("pp_full_ovf",   {31'd0, overflow}, 32'd0);
        check_eq("pp_full_cnt",   {16'd0, frame_cnt}, 32'd1);
        check_eq("pp_full_max",   frame_max, 32'd255);
        do_read("pp_full_rd0",   8'd0,   32'd0);
        do_read("pp_full_rd255", 8'd255, 32'd255);
        stream(32'd9999, 32'd0, 1);
        check_eq("pp_ovf_set", {31'd0, overflow}, 32'd1);
        pulse_ack();
        check_eq("pp_b_cnt",   {16'd0, frame_cnt}, 32'd2);
        check_eq("pp_b_max",   frame_max, 32'd1255);
        check_eq("pp_b_ready", {31'd0, frame_ready}, 32'd1);
        do_read("pp_b_rd0",   8'd0,   32'd1000);
        do_read("pp_b_rd200", 8'd200, 32'd1200);
        check_eq("pp_ovf_sticky", {31'd0, overflow}, 32'd1);

        // ack and read in the same cycle return the old frame
        frame_ack = 1'b1; rd_req = 1'b1; rd_addr = 8'd7; tick();
        frame_ack = 1'b0; rd_req = 1'b0;
        check_eq("ackrd_data",  rd_data, 32'd1007);
        check_eq("ackrd_ready", {31'd0, frame_ready}, 32'd0);

        // ---- Same-edge ack ----
        do_reset(1);
        stream(32'd5, 32'd1, 256);
        check_eq("se_f1_cnt", {16'd0, frame_cnt}, 32'd1);
        stream(32'd2000, 32'd1, 255);
        in_valid = 1'b1; in_data = 32'd2255; frame_ack = 1'b1;
        tick();
        in_valid = 1'b0; frame_ack = 1'b0;
        check_eq("se_ready", {31'd0, frame_ready}, 32'd1);
        check_eq("se_cnt",   {16'd0, frame_cnt}, 32'd2);
        check_eq("se_ovf",   {31'd0, overflow}, 32'd0);
        check_eq("se_max",   frame_max, 32'd2255);
        do_read("se_rd10", 8'd10, 32'd2010);

        // ---- Mid-operation reset ----
        stream(32'd7000, 32'd1, 100);
        RST = 1'b1; rd_req = 1'b1; rd_addr = 8'd3;
        tick();
        RST = 1'b0; rd_req = 1'b0;
        check_eq("mr_rvalid", {31'd0, rd_valid}, 32'd0);
        check_eq("mr_ready",  {31'd0, frame_ready}, 32'd0);
        check_eq("mr_cnt",    {16'd0, frame_cnt}, 32'd0);
        check_eq("mr_max",    frame_max, 32'd0);
        tick();
        check_eq("mr_rvalid2", {31'd0, rd_valid}, 32'd0);
        stream(32'd500, 32'd1, 256);
        check_eq("mr_new_cnt", {16'd0, frame_cnt}, 32'd1);
        check_eq("mr_new_max", frame_max, 32'd755);
        do_read("mr_rd0",   8'd0,   32'd500);
        do_read("mr_rd99",  8'd99,  32'd599);
        do_read("mr_rd200", 8'd200, 32'd700);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
